// File: rtl/osd_mixer_pkg.sv
// Shared types and constants for the OSD output mixer: default palette, blend width, pixel struct.
// No timing of its own; no flow control.
package osd_mixer_pkg;

    localparam int PKG_COLOR_W = 8;

    typedef struct packed {
        logic [PKG_COLOR_W-1:0] r;
        logic [PKG_COLOR_W-1:0] g;
        logic [PKG_COLOR_W-1:0] b;
    } rgb_t;

    // Bit i set means channel is all-ones in default palette entry i (entries >= 4 are black)
    localparam logic [3:0] DEF_PAL_R = 4'b1100;
    localparam logic [3:0] DEF_PAL_G = 4'b1100;
    localparam logic [3:0] DEF_PAL_B = 4'b1010;

    typedef enum logic {
        PAL_IDLE    = 1'b0,
        PAL_PENDING = 1'b1
    } pal_state_e;

    function automatic int blend_w(input int color_w, input int alpha_w);
        return 2 * color_w + alpha_w + 1;
    endfunction

endpackage

// File: rtl/osd_blend_ch.sv
// One colour channel of the alpha blend: S2 products, S3 rounded sum; output zero when DE is low.
// Latency 2 cycles from the S1 inputs; always accepts, no backpressure.
module osd_blend_ch
    import osd_mixer_pkg::*;
#(
    parameter int COLOR_W = 8,
    parameter int ALPHA_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] vid_i,
    input  logic [COLOR_W-1:0] osd_i,
    input  logic [ALPHA_W:0]   alpha_i,
    input  logic               de_s2_i,
    output logic [COLOR_W-1:0] pix_o
);

    localparam int PROD_W = COLOR_W + ALPHA_W + 1;
    localparam int SUM_W  = blend_w(COLOR_W, ALPHA_W);
    localparam logic [ALPHA_W:0] ALPHA_FULL = (ALPHA_W+1)'(2**ALPHA_W);
    localparam logic [SUM_W-1:0] ROUND      = SUM_W'(2**(ALPHA_W-1));

    logic [ALPHA_W:0]     alpha_inv;
    logic [PROD_W-1:0]    osd_prod_d, osd_prod_q;
    logic [PROD_W-1:0]    vid_prod_d, vid_prod_q;
    logic [SUM_W-1:0]     sum;
    logic [COLOR_W-1:0]   pix_d, pix_q;

    always_comb begin
        alpha_inv  = ALPHA_FULL - alpha_i;
        osd_prod_d = PROD_W'(osd_i) * PROD_W'(alpha_i);
        vid_prod_d = PROD_W'(vid_i) * PROD_W'(alpha_inv);
        // Weights sum to ALPHA_FULL, so the shifted result always fits COLOR_W
        sum        = SUM_W'(osd_prod_q) + SUM_W'(vid_prod_q) + ROUND;
        pix_d      = de_s2_i ? COLOR_W'(sum >> ALPHA_W) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            osd_prod_q <= '0;
            vid_prod_q <= '0;
            pix_q      <= '0;
        end else begin
            osd_prod_q <= osd_prod_d;
            vid_prod_q <= vid_prod_d;
            pix_q      <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/osd_output_mixer.sv
// Blends a palette-coloured OSD over video with vsync-synchronous palette commit and active-line count.
// Pixel and sync latency 3 cycles; streaming, no backpressure.
module osd_output_mixer
    import osd_mixer_pkg::*;
#(
    parameter int COLOR_W        = 8,
    parameter int OSD_COLOR_BITS = 2,
    parameter int ALPHA_W        = 4,
    parameter int LINECNT_W      = 11
) (
    input  logic                      PCLK_i,
    input  logic                      reset,
    input  logic [COLOR_W-1:0]        R_i,
    input  logic [COLOR_W-1:0]        G_i,
    input  logic [COLOR_W-1:0]        B_i,
    input  logic                      HSYNC_i,
    input  logic                      VSYNC_i,
    input  logic                      DE_i,
    input  logic                      osd_enable_i,
    input  logic [OSD_COLOR_BITS-1:0] osd_color_i,
    input  logic [ALPHA_W:0]          osd_alpha_i,
    input  logic                      pal_we_i,
    input  logic [OSD_COLOR_BITS-1:0] pal_addr_i,
    input  logic [3*COLOR_W-1:0]      pal_data_i,
    input  logic                      pal_commit_i,
    output logic [COLOR_W-1:0]        R_o,
    output logic [COLOR_W-1:0]        G_o,
    output logic [COLOR_W-1:0]        B_o,
    output logic                      HSYNC_o,
    output logic                      VSYNC_o,
    output logic                      DE_o,
    output logic                      pal_pending_o,
    output logic [LINECNT_W-1:0]      active_lines_o
);

    localparam int NPAL  = 2**OSD_COLOR_BITS;
    localparam int PAL_W = 3 * COLOR_W;
    localparam logic [ALPHA_W:0] ALPHA_FULL = (ALPHA_W+1)'(2**ALPHA_W);

    function automatic logic [PAL_W-1:0] pal_default(input int idx);
        logic [COLOR_W-1:0] r, g, b;
        r = '0;
        g = '0;
        b = '0;
        if (idx < 4) begin
            r = {COLOR_W{DEF_PAL_R[idx[1:0]]}};
            g = {COLOR_W{DEF_PAL_G[idx[1:0]]}};
            b = {COLOR_W{DEF_PAL_B[idx[1:0]]}};
        end
        return {r, g, b};
    endfunction

    logic [PAL_W-1:0]     shadow_d [NPAL];
    logic [PAL_W-1:0]     shadow_q [NPAL];
    logic [PAL_W-1:0]     active_d [NPAL];
    logic [PAL_W-1:0]     active_q [NPAL];
    pal_state_e           pal_state_d, pal_state_q;

    logic [PAL_W-1:0]     vid_d, vid_q;
    logic [PAL_W-1:0]     osd_d, osd_q;
    logic [ALPHA_W:0]     alpha_d, alpha_q;
    logic [2:0]           hs_d, hs_q;
    logic [2:0]           vs_d, vs_q;
    logic [2:0]           de_d, de_q;

    logic [LINECNT_W-1:0] line_cnt_d, line_cnt_q;
    logic [LINECNT_W-1:0] active_lines_d, active_lines_q;

    logic                 vs_fall;
    logic                 de_rise;
    logic                 pal_copy;

    always_comb begin
        vs_fall  = vs_q[0] & ~VSYNC_i;
        de_rise  = DE_i & ~de_q[0];

        shadow_d = shadow_q;
        if (pal_we_i) begin
            shadow_d[pal_addr_i] = pal_data_i;
        end

        // A commit arriving on the edge cycle is served immediately and never shows as pending
        pal_copy    = vs_fall & ((pal_state_q == PAL_PENDING) | pal_commit_i);
        active_d    = pal_copy ? shadow_d : active_q;
        pal_state_d = pal_state_q;
        if (pal_copy) begin
            pal_state_d = PAL_IDLE;
        end else if (pal_commit_i) begin
            pal_state_d = PAL_PENDING;
        end

        // S1 looks up the post-copy palette so the edge pixel already sees new colours
        vid_d = {R_i, G_i, B_i};
        osd_d = active_d[osd_color_i];
        if (!osd_enable_i) begin
            alpha_d = '0;
        end else if (osd_alpha_i > ALPHA_FULL) begin
            alpha_d = ALPHA_FULL;
        end else begin
            alpha_d = osd_alpha_i;
        end

        hs_d = {hs_q[1:0], HSYNC_i};
        vs_d = {vs_q[1:0], VSYNC_i};
        de_d = {de_q[1:0], DE_i};

        line_cnt_d     = line_cnt_q;
        active_lines_d = active_lines_q;
        if (vs_fall) begin
            active_lines_d = line_cnt_q;
            line_cnt_d     = de_rise ? LINECNT_W'(1) : '0;
        end else if (de_rise && (line_cnt_q != '1)) begin
            line_cnt_d = line_cnt_q + LINECNT_W'(1);
        end
    end

    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            for (int i = 0; i < NPAL; i++) begin
                shadow_q[i] <= pal_default(i);
                active_q[i] <= pal_default(i);
            end
            pal_state_q    <= PAL_IDLE;
            vid_q          <= '0;
            osd_q          <= '0;
            alpha_q        <= '0;
            hs_q           <= '1;
            vs_q           <= '1;
            de_q           <= '0;
            line_cnt_q     <= '0;
            active_lines_q <= '0;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pal_state_q    <= pal_state_d;
            vid_q          <= vid_d;
            osd_q          <= osd_d;
            alpha_q        <= alpha_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            de_q           <= de_d;
            line_cnt_q     <= line_cnt_d;
            active_lines_q <= active_lines_d;
        end
    end

    osd_blend_ch #(.COLOR_W(COLOR_W), .ALPHA_W(ALPHA_W)) u_blend_r (
        .clk     (PCLK_i),
        .reset   (reset),
        .vid_i   (vid_q[2*COLOR_W +: COLOR_W]),
        .osd_i   (osd_q[2*COLOR_W +: COLOR_W]),
        .alpha_i (alpha_q),
        .de_s2_i (de_q[1]),
        .pix_o   (R_o)
    );

    osd_blend_ch #(.COLOR_W(COLOR_W), .ALPHA_W(ALPHA_W)) u_blend_g (
        .clk     (PCLK_i),
        .reset   (reset),
        .vid_i   (vid_q[COLOR_W +: COLOR_W]),
        .osd_i   (osd_q[COLOR_W +: COLOR_W]),
        .alpha_i (alpha_q),
        .de_s2_i (de_q[1]),
        .pix_o   (G_o)
    );

    osd_blend_ch #(.COLOR_W(COLOR_W), .ALPHA_W(ALPHA_W)) u_blend_b (
        .clk     (PCLK_i),
        .reset   (reset),
        .vid_i   (vid_q[0 +: COLOR_W]),
        .osd_i   (osd_q[0 +: COLOR_W]),
        .alpha_i (alpha_q),
        .de_s2_i (de_q[1]),
        .pix_o   (B_o)
    );

    assign HSYNC_o        = hs_q[2];
    assign VSYNC_o        = vs_q[2];
    assign DE_o           = de_q[2];
    assign pal_pending_o  = (pal_state_q == PAL_PENDING);
    assign active_lines_o = active_lines_q;

endmodule

// File: tb/tb_osd_output_mixer.sv
// Bench for osd_output_mixer: cycle-level reference model plus directed palette, alpha and line-count steps.
module tb_osd_output_mixer;
    import osd_mixer_pkg::*;

    localparam int BLANK = 5;
    localparam logic [23:0] DEF_PAL [4] = '{24'h000000, 24'h0000FF, 24'hFFFF00, 24'hFFFFFF};

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  r_i, g_i, b_i;
    logic        hs_i, vs_i, de_i;
    logic        osd_en;
    logic [1:0]  osd_col;
    logic [4:0]  osd_alpha;
    logic        pal_we;
    logic [1:0]  pal_addr;
    logic [23:0] pal_data;
    logic        pal_commit;
    logic [7:0]  R_o, G_o, B_o;
    logic        HSYNC_o, VSYNC_o, DE_o, pal_pending_o;
    logic [10:0] active_lines_o;

    osd_output_mixer dut (
        .PCLK_i        (clk),
        .reset         (reset),
        .R_i           (r_i),
        .G_i           (g_i),
        .B_i           (b_i),
        .HSYNC_i       (hs_i),
        .VSYNC_i       (vs_i),
        .DE_i          (de_i),
        .osd_enable_i  (osd_en),
        .osd_color_i   (osd_col),
        .osd_alpha_i   (osd_alpha),
        .pal_we_i      (pal_we),
        .pal_addr_i    (pal_addr),
        .pal_data_i    (pal_data),
        .pal_commit_i  (pal_commit),
        .R_o           (R_o),
        .G_o           (G_o),
        .B_o           (B_o),
        .HSYNC_o       (HSYNC_o),
        .VSYNC_o       (VSYNC_o),
        .DE_o          (DE_o),
        .pal_pending_o (pal_pending_o),
        .active_lines_o(active_lines_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        rgb_t pix;
        logic hs;
        logic vs;
        logic de;
    } out_t;

    logic [23:0] m_shadow [4];
    logic [23:0] m_active [4];
    bit          m_pending;
    logic [10:0] m_cnt, m_lines;
    bit          m_vs_prev, m_de_prev;
    out_t        pipe [3];
    int          checks = 0;
    int          errors = 0;
    bit          rand_px = 1'b0;

    function automatic logic [7:0] mix(input int osd, input int vid, input int a);
        return 8'((osd * a + vid * (16 - a) + 8) / 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare outputs.
    task automatic step();
        out_t        e;
        int          a;
        logic [23:0] osd;
        bit          vs_fall, de_rise, copy;
        @(posedge clk);
        if (reset) begin
            m_shadow  = DEF_PAL;
            m_active  = DEF_PAL;
            m_pending = 1'b0;
            m_cnt     = '0;
            m_lines   = '0;
            m_vs_prev = 1'b1;
            m_de_prev = 1'b0;
            e.pix = '0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
            pipe[0] = e; pipe[1] = e; pipe[2] = e;
        end else begin
            vs_fall = m_vs_prev && !vs_i;
            de_rise = de_i && !m_de_prev;
            if (pal_we) m_shadow[pal_addr] = pal_data;
            copy = vs_fall && (m_pending || pal_commit);
            if (copy) m_active = m_shadow;
            if (copy) m_pending = 1'b0;
            else if (pal_commit) m_pending = 1'b1;

            osd = m_active[osd_col];
            a   = !osd_en ? 0 : ((osd_alpha > 16) ? 16 : int'(osd_alpha));
            e.hs = hs_i; e.vs = vs_i; e.de = de_i;
            e.pix = '0;
            if (de_i) begin
                e.pix.r = mix(osd[23:16], r_i, a);
                e.pix.g = mix(osd[15:8],  g_i, a);
                e.pix.b = mix(osd[7:0],   b_i, a);
            end

            if (vs_fall) begin
                m_lines = m_cnt;
                m_cnt   = de_rise ? 11'd1 : 11'd0;
            end else if (de_rise && m_cnt != 11'h7FF) begin
                m_cnt = m_cnt + 11'd1;
            end
            m_vs_prev = vs_i;
            m_de_prev = de_i;
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
        end
        #1;
        chk("rgb",     {8'h0, R_o, G_o, B_o}, {8'h0, pipe[2].pix});
        chk("sync",    {29'h0, HSYNC_o, VSYNC_o, DE_o}, {29'h0, pipe[2].hs, pipe[2].vs, pipe[2].de});
        chk("pending", {31'h0, pal_pending_o}, {31'h0, m_pending});
        chk("lines",   {21'h0, active_lines_o}, {21'h0, m_lines});
    endtask

    task automatic run_line(input bit vs, input bit de_on, input int act);
        for (int c = 0; c < act + BLANK; c++) begin
            vs_i = vs;
            de_i = de_on && (c < act);
            hs_i = !((c >= act + 1) && (c < act + 3));
            if (rand_px) begin
                r_i        = 8'($urandom);
                g_i        = 8'($urandom);
                b_i        = 8'($urandom);
                osd_en     = 1'($urandom_range(0, 1));
                osd_col    = 2'($urandom);
                osd_alpha  = 5'($urandom_range(0, 31));
                pal_we     = ($urandom_range(0, 15) == 0);
                pal_addr   = 2'($urandom);
                pal_data   = 24'($urandom);
                pal_commit = ($urandom_range(0, 63) == 0);
            end
            step();
        end
    endtask

    task automatic frame(input int n_act, input bit de_in_vsync, input int act);
        run_line(1'b0, de_in_vsync, act);
        if (!de_in_vsync) run_line(1'b0, 1'b0, act);
        for (int l = 0; l < n_act; l++) run_line(1'b1, 1'b1, act);
        run_line(1'b1, 1'b0, act);
    endtask

    // Hold the current pixel inputs with DE high long enough to reach the outputs, then compare.
    task automatic settle(input string tag, input logic [23:0] exp);
        vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b1;
        repeat (4) step();
        chk(tag, {8'h0, R_o, G_o, B_o}, {8'h0, exp});
        de_i = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; hs_i = 1'b1; vs_i = 1'b1; de_i = 1'b0;
        r_i = 8'h0; g_i = 8'h0; b_i = 8'h0;
        osd_en = 1'b0; osd_col = 2'd0; osd_alpha = 5'd0;
        pal_we = 1'b0; pal_addr = 2'd0; pal_data = 24'h0; pal_commit = 1'b0;
        repeat (3) step();
        chk("reset_hsync", {31'h0, HSYNC_o}, 32'd1);
        chk("reset_vsync", {31'h0, VSYNC_o}, 32'd1);
        chk("reset_de",    {31'h0, DE_o}, 32'd0);
        chk("reset_lines", {21'h0, active_lines_o}, 32'd0);
        reset = 1'b0;

        // Plain video pass-through with OSD disabled
        {r_i, g_i, b_i} = 24'h123456;
        frame(4, 1'b0, 16);
        settle("video_pass", 24'h123456);

        // Full and half alpha over known video
        osd_en = 1'b1; osd_col = 2'd2; osd_alpha = 5'd16;
        {r_i, g_i, b_i} = 24'h000000;
        settle("pal2_full", 24'hFFFF00);
        osd_alpha = 5'd8; {r_i, g_i, b_i} = 24'h00FF80;
        settle("pal2_half", 24'h80FF40);

        // Alpha saturation, alpha zero, OSD disabled
        osd_alpha = 5'd31;
        settle("alpha_sat", 24'hFFFF00);
        osd_alpha = 5'd0;
        settle("alpha_zero", 24'h00FF80);
        osd_alpha = 5'd16; osd_en = 1'b0;
        settle("osd_off", 24'h00FF80);

        // Mid-frame write and commit of entry1, applied at the next vsync fall
        osd_en = 1'b1; osd_col = 2'd1;
        settle("entry1_default", 24'h0000FF);
        run_line(1'b0, 1'b0, 8);
        run_line(1'b1, 1'b1, 8);
        run_line(1'b1, 1'b1, 8);
        pal_we = 1'b1; pal_addr = 2'd1; pal_data = 24'hABCDEF; pal_commit = 1'b1;
        step();
        pal_we = 1'b0; pal_commit = 1'b0;
        chk("pending_set", {31'h0, pal_pending_o}, 32'd1);
        run_line(1'b1, 1'b1, 8);
        run_line(1'b1, 1'b0, 8);
        settle("entry1_before_vs", 24'h0000FF);
        vs_i = 1'b0; de_i = 1'b1;
        step();
        chk("pending_clear_at_vs", {31'h0, pal_pending_o}, 32'd0);
        settle("entry1_after_vs", 24'hABCDEF);

        // Write on the copy cycle is bypassed into the active palette
        pal_commit = 1'b1;
        step();
        pal_commit = 1'b0;
        chk("pending_set2", {31'h0, pal_pending_o}, 32'd1);
        vs_i = 1'b0; pal_we = 1'b1; pal_addr = 2'd3; pal_data = 24'h102030;
        step();
        pal_we = 1'b0;
        chk("pending_clear2", {31'h0, pal_pending_o}, 32'd0);
        osd_col = 2'd3;
        settle("entry3_bypass", 24'h102030);
        vs_i = 1'b1;
        step();
        vs_i = 1'b0; pal_commit = 1'b1;
        step();
        pal_commit = 1'b0;
        chk("commit_on_edge", {31'h0, pal_pending_o}, 32'd0);
        repeat (3) step();

        // Line counting, including a DE rise coincident with the vsync fall
        rand_px = 1'b1;
        frame(480, 1'b0, 8);
        frame(479, 1'b1, 8);
        chk("lines_480", {21'h0, active_lines_o}, 32'd480);
        frame(3, 1'b0, 8);
        chk("lines_480_coincident", {21'h0, active_lines_o}, 32'd480);
        rand_px = 1'b0;
        pal_we = 1'b0; pal_commit = 1'b0;

        // Reset mid-frame restores outputs, counter and default palette
        run_line(1'b1, 1'b1, 8);
        pal_commit = 1'b1;
        step();
        pal_commit = 1'b0;
        chk("pending_before_reset", {31'h0, pal_pending_o}, 32'd1);
        de_i = 1'b1; reset = 1'b1;
        pal_we = 1'b1; pal_addr = 2'd0; pal_data = 24'hFFFFFF;
        step();
        chk("mid_reset_rgb",   {8'h0, R_o, G_o, B_o}, 32'h0);
        chk("mid_reset_sync",  {29'h0, HSYNC_o, VSYNC_o, DE_o}, 32'b110);
        chk("mid_reset_pend",  {31'h0, pal_pending_o}, 32'd0);
        chk("mid_reset_lines", {21'h0, active_lines_o}, 32'd0);
        reset = 1'b0; pal_we = 1'b0;
        osd_en = 1'b1; osd_alpha = 5'd16; {r_i, g_i, b_i} = 24'h555555;
        osd_col = 2'd0;
        settle("pal0_after_reset", 24'h000000);
        osd_col = 2'd1;
        settle("pal1_after_reset", 24'h0000FF);
        osd_col = 2'd3;
        settle("pal3_after_reset", 24'hFFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
